fetch_queue: RTL and testbench

- Instruction-fetch front end that drives the single-port instruction RAM (iram) and buffers returned words for the decode stage.
- Generates sequential PCs and issues one read per cycle against the iram's fixed 1-cycle latency.
- Captures each returned word with its PC in a small FIFO and presents it to decode through a valid/ready handshake.
- Handles branch/exception redirects by flushing the FIFO and discarding the in-flight response.

---
 rtl/fetch_queue_if.sv | 29 ++
 rtl/fetch_queue.sv | 93 +++++++++
 tb/tb_fetch_queue.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Fetch-side bus bundle: redirect input, iram request/response and decode handshake.
// The master modport is the fetch_queue side; slave is the iram/decode environment.
interface fetch_queue_if;
    logic        fetch_redirect;
    logic [31:0] fetch_raddr;
    logic        iram_valid;
    logic        iram_instr;
    logic [31:0] iram_addr;
    logic [31:0] iram_wdata;
    logic [3:0]  iram_wstrb;
    logic [31:0] iram_rdata;
    logic        iram_ready;
    logic        dec_valid;
    logic [31:0] dec_pc;
    logic [31:0] dec_instr;
    logic        dec_ready;

    modport master (
        input  fetch_redirect, fetch_raddr, iram_rdata, iram_ready, dec_ready,
        output iram_valid, iram_instr, iram_addr, iram_wdata, iram_wstrb,
        output dec_valid, dec_pc, dec_instr
    );

    modport slave (
        output fetch_redirect, fetch_raddr, iram_rdata, iram_ready, dec_ready,
        input  iram_valid, iram_instr, iram_addr, iram_wdata, iram_wstrb,
        input  dec_valid, dec_pc, dec_instr
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: sequential PC generation against a 1-cycle iram,
// a small {pc, instr} FIFO toward decode, and redirect flush with in-flight drop.
module fetch_queue #(
    parameter int unsigned fifo_depth = 4,
    parameter logic [31:0] reset_pc   = 32'h0000_0000
) (
    input logic           clk,
    input logic           rst,
    fetch_queue_if.master bus
);
    localparam int unsigned PTR_W = $clog2(fifo_depth);
    localparam logic [PTR_W:0] DEPTH = (PTR_W + 1)'(fifo_depth);

    logic [31:0]      pc;
    logic [31:0]      req_pc;
    logic             inflight;
    logic             stale;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;
    logic [31:0]      fifo_pc    [fifo_depth];
    logic [31:0]      fifo_instr [fifo_depth];

    logic             issue;
    logic             push;
    logic             pop;
    logic             head_valid;
    logic [PTR_W:0]   occupancy;

    // Occupancy counts the in-flight slot; same-cycle pops are deliberately not credited.
    always_comb begin
        occupancy  = count + {{PTR_W{1'b0}}, inflight};
        issue      = !rst && !bus.fetch_redirect && (occupancy < DEPTH);
        head_valid = (count != '0) && !bus.fetch_redirect;
        push       = bus.iram_ready && inflight && !stale;
        pop        = head_valid && bus.dec_ready;
    end

    assign bus.iram_valid = issue;
    assign bus.iram_instr = 1'b1;
    assign bus.iram_addr  = pc;
    assign bus.iram_wdata = '0;
    assign bus.iram_wstrb = '0;
    assign bus.dec_valid  = head_valid;
    assign bus.dec_pc     = fifo_pc[rd_ptr];
    assign bus.dec_instr  = fifo_instr[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= reset_pc;
            req_pc   <= '0;
            inflight <= 1'b0;
            stale    <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            for (int unsigned i = 0; i < fifo_depth; i++) begin
                fifo_pc[i]    <= '0;
                fifo_instr[i] <= '0;
            end
        end else if (bus.fetch_redirect) begin
            // Flush: a response arriving now or for an older request must never reach decode.
            pc       <= bus.fetch_raddr & ~32'd3;
            inflight <= 1'b0;
            stale    <= inflight | issue;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            stale <= 1'b0;
            if (issue) begin
                req_pc   <= pc;
                pc       <= pc + 32'd4;
                inflight <= 1'b1;
            end else begin
                inflight <= 1'b0;
            end
            if (push) begin
                fifo_pc[wr_ptr]    <= req_pc;
                fifo_instr[wr_ptr] <= bus.iram_rdata;
                wr_ptr             <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (!push && pop) begin
                count <= count - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus randomized traffic
// checked against a queue-based reference of the fetch stream.
module tb_fetch_queue;
    localparam int DEPTH = 4;

    logic clk;
    logic rst;
    fetch_queue_if bus ();

    fetch_queue #(.fifo_depth(DEPTH), .reset_pc(32'h0000_0000)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference: buffered PCs in order, one in-flight request, next fetch PC.
    logic [31:0] m_q[$];
    int          m_inflight;
    logic [31:0] m_ipc;
    logic [31:0] m_pc;
    logic        prev_issue;
    logic [31:0] prev_addr;
    logic        exp_iv;
    logic        exp_dv;
    logic [31:0] exp_ia;
    logic [31:0] exp_dpc;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'hA5A5_A5A5;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_inflight = 0;
        m_ipc      = '0;
        m_pc       = 32'h0000_0000;
        prev_issue = 1'b0;
        prev_addr  = '0;
    endtask

    task automatic set_idle();
        bus.fetch_redirect = 1'b0;
        bus.fetch_raddr    = '0;
        bus.dec_ready      = 1'b0;
        bus.iram_ready     = 1'b0;
        bus.iram_rdata     = '0;
    endtask

    // Called at a negedge: apply this cycle's inputs and iram response, compute expectations.
    task automatic drive(input logic redir, input logic [31:0] raddr, input logic dready);
        bus.fetch_redirect = redir;
        bus.fetch_raddr    = raddr;
        bus.dec_ready      = dready;
        bus.iram_ready     = prev_issue;
        bus.iram_rdata     = prev_issue ? mem(prev_addr) : $urandom;
        exp_iv  = !redir && ((m_q.size() + m_inflight) < DEPTH);
        exp_ia  = m_pc;
        exp_dv  = (m_q.size() != 0) && !redir;
        exp_dpc = (m_q.size() != 0) ? m_q[0] : 32'h0;
        #1;
    endtask

    // Apply the clock edge to the reference, remember the DUT request, move to next negedge.
    task automatic advance();
        if (bus.fetch_redirect) begin
            m_q.delete();
            m_inflight = 0;
            m_pc = bus.fetch_raddr & ~32'd3;
        end else begin
            if (exp_dv && bus.dec_ready) void'(m_q.pop_front());
            if (m_inflight != 0) m_q.push_back(m_ipc);
            m_inflight = exp_iv ? 1 : 0;
            if (exp_iv) begin
                m_ipc = m_pc;
                m_pc  = m_pc + 32'd4;
            end
        end
        prev_issue = bus.iram_valid;
        prev_addr  = bus.iram_addr;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_idle();
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_idle();
        @(negedge clk);
        checks++; if (bus.iram_valid !== 1'b0) begin failures++; $display("FAIL reset_iram_valid got=%b exp=0", bus.iram_valid); end
        checks++; if (bus.dec_valid !== 1'b0) begin failures++; $display("FAIL reset_dec_valid got=%b exp=0", bus.dec_valid); end
        checks++; if (bus.dec_pc !== 32'h0) begin failures++; $display("FAIL reset_dec_pc got=%h exp=0", bus.dec_pc); end
        checks++; if (bus.dec_instr !== 32'h0) begin failures++; $display("FAIL reset_dec_instr got=%h exp=0", bus.dec_instr); end
        checks++; if (bus.iram_instr !== 1'b1) begin failures++; $display("FAIL reset_iram_instr got=%b exp=1", bus.iram_instr); end
        checks++; if (bus.iram_wdata !== 32'h0) begin failures++; $display("FAIL reset_iram_wdata got=%h exp=0", bus.iram_wdata); end
        checks++; if (bus.iram_wstrb !== 4'h0) begin failures++; $display("FAIL reset_iram_wstrb got=%h exp=0", bus.iram_wstrb); end
        checks++; if (bus.iram_addr !== 32'h0) begin failures++; $display("FAIL reset_iram_addr got=%h exp=0", bus.iram_addr); end
    endtask

    task automatic test_stream();
        do_reset();
        for (int c = 0; c < 12; c++) begin
            logic [31:0] epc;
            drive(1'b0, 32'h0, 1'b1);
            checks++; if (bus.iram_valid !== 1'b1 || bus.iram_addr !== 32'(4 * c)) begin
                failures++; $display("FAIL stream_issue cyc=%0d got=%b/%h exp=1/%h", c, bus.iram_valid, bus.iram_addr, 32'(4 * c));
            end
            if (c >= 2) begin
                epc = 32'(4 * (c - 2));
                checks++; if (bus.dec_valid !== 1'b1 || bus.dec_pc !== epc || bus.dec_instr !== mem(epc)) begin
                    failures++; $display("FAIL stream_dec cyc=%0d got=%b/%h/%h exp=1/%h/%h", c, bus.dec_valid, bus.dec_pc, bus.dec_instr, epc, mem(epc));
                end
            end else begin
                checks++; if (bus.dec_valid !== 1'b0) begin failures++; $display("FAIL stream_early_valid cyc=%0d got=%b exp=0", c, bus.dec_valid); end
            end
            advance();
        end
    endtask

    task automatic test_backpressure();
        int issues = 0;
        logic seen_issue = 1'b0;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            drive(1'b0, 32'h0, 1'b0);
            if (bus.iram_valid === 1'b1) issues++;
            checks++; if (bus.iram_valid !== exp_iv) begin failures++; $display("FAIL bp_iram_valid cyc=%0d got=%b exp=%b", c, bus.iram_valid, exp_iv); end
            advance();
        end
        checks++; if (issues != DEPTH) begin failures++; $display("FAIL bp_issue_count got=%0d exp=%0d", issues, DEPTH); end
        for (int c = 0; c < 8; c++) begin
            logic [31:0] epc;
            drive(1'b0, 32'h0, 1'b1);
            epc = 32'(4 * c);
            checks++; if (bus.dec_valid !== 1'b1 || bus.dec_pc !== epc || bus.dec_instr !== mem(epc)) begin
                failures++; $display("FAIL bp_drain cyc=%0d got=%b/%h/%h exp=1/%h/%h", c, bus.dec_valid, bus.dec_pc, bus.dec_instr, epc, mem(epc));
            end
            if (bus.iram_valid === 1'b1 && !seen_issue) begin
                seen_issue = 1'b1;
                checks++; if (bus.iram_addr !== 32'h10) begin failures++; $display("FAIL bp_resume_addr got=%h exp=00000010", bus.iram_addr); end
            end
            advance();
        end
        checks++; if (seen_issue !== 1'b1) begin failures++; $display("FAIL bp_resume got=%b exp=1", seen_issue); end
    endtask

    task automatic test_redirect();
        do_reset();
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, 32'h0, 1'b0);
            advance();
        end
        drive(1'b1, 32'h0000_0103, 1'b1);
        checks++; if (bus.dec_valid !== 1'b0 || bus.iram_valid !== 1'b0) begin
            failures++; $display("FAIL redir_cycle got=dv%b/iv%b exp=dv0/iv0", bus.dec_valid, bus.iram_valid);
        end
        advance();
        for (int c = 0; c < 8; c++) begin
            logic [31:0] epc;
            drive(1'b0, 32'h0, 1'b1);
            checks++; if (bus.iram_valid !== 1'b1 || bus.iram_addr !== 32'h100 + 32'(4 * c)) begin
                failures++; $display("FAIL redir_issue cyc=%0d got=%b/%h exp=1/%h", c, bus.iram_valid, bus.iram_addr, 32'h100 + 32'(4 * c));
            end
            if (c >= 2) begin
                epc = 32'h100 + 32'(4 * (c - 2));
                checks++; if (bus.dec_valid !== 1'b1 || bus.dec_pc !== epc || bus.dec_instr !== mem(epc)) begin
                    failures++; $display("FAIL redir_dec cyc=%0d got=%b/%h/%h exp=1/%h/%h", c, bus.dec_valid, bus.dec_pc, bus.dec_instr, epc, mem(epc));
                end
            end else begin
                checks++; if (bus.dec_valid !== 1'b0) begin failures++; $display("FAIL redir_stale cyc=%0d got=%b/%h exp=0", c, bus.dec_valid, bus.dec_pc); end
            end
            advance();
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, 32'h0, 1'b0);
            advance();
        end
        for (int c = 4; c < 12; c++) begin
            logic [31:0] epc;
            drive(1'b0, 32'h0, 1'b1);
            epc = 32'(4 * (c - 4));
            if (c == 4) begin
                checks++; if (bus.iram_valid !== 1'b0) begin failures++; $display("FAIL b2b_full_stall got=%b exp=0", bus.iram_valid); end
            end
            if (c == 5) begin
                checks++; if (bus.iram_valid !== 1'b1 || bus.iram_addr !== 32'h10) begin
                    failures++; $display("FAIL b2b_count_held got=%b/%h exp=1/00000010", bus.iram_valid, bus.iram_addr);
                end
            end
            checks++; if (bus.dec_valid !== 1'b1 || bus.dec_pc !== epc || bus.dec_instr !== mem(epc)) begin
                failures++; $display("FAIL b2b_order cyc=%0d got=%b/%h/%h exp=1/%h/%h", c, bus.dec_valid, bus.dec_pc, bus.dec_instr, epc, mem(epc));
            end
            advance();
        end
    endtask

    task automatic test_wrap();
        do_reset();
        drive(1'b1, 32'hFFFF_FFF8, 1'b1);
        advance();
        for (int c = 0; c < 6; c++) begin
            logic [31:0] epc;
            drive(1'b0, 32'h0, 1'b1);
            if (c >= 2) begin
                epc = 32'hFFFF_FFF8 + 32'(4 * (c - 2));
                checks++; if (bus.dec_valid !== 1'b1 || bus.dec_pc !== epc || bus.dec_instr !== mem(epc)) begin
                    failures++; $display("FAIL wrap_dec cyc=%0d got=%b/%h/%h exp=1/%h/%h", c, bus.dec_valid, bus.dec_pc, bus.dec_instr, epc, mem(epc));
                end
            end
            if (c == 2) begin
                checks++; if (bus.iram_addr !== 32'h0) begin failures++; $display("FAIL wrap_addr got=%h exp=00000000", bus.iram_addr); end
            end
            advance();
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 32'h0, 1'b0);
            advance();
        end
        drive(1'b0, 32'h0, 1'b0);
        checks++; if (bus.dec_valid !== 1'b1) begin failures++; $display("FAIL mid_pre_valid got=%b exp=1", bus.dec_valid); end
        rst = 1'b1;
        #1;
        checks++; if (bus.iram_valid !== 1'b0 || bus.dec_valid !== 1'b0) begin
            failures++; $display("FAIL mid_rst_valid got=iv%b/dv%b exp=iv0/dv0", bus.iram_valid, bus.dec_valid);
        end
        checks++; if (bus.dec_pc !== 32'h0 || bus.dec_instr !== 32'h0) begin
            failures++; $display("FAIL mid_rst_data got=%h/%h exp=0/0", bus.dec_pc, bus.dec_instr);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        prev_issue = 1'b1;
        prev_addr  = 32'h8;
        for (int c = 0; c < 6; c++) begin
            drive(1'b0, 32'h0, 1'b1);
            checks++; if (bus.iram_valid !== 1'b1 || bus.iram_addr !== 32'(4 * c)) begin
                failures++; $display("FAIL mid_restart cyc=%0d got=%b/%h exp=1/%h", c, bus.iram_valid, bus.iram_addr, 32'(4 * c));
            end
            if (c < 2) begin
                checks++; if (bus.dec_valid !== 1'b0) begin failures++; $display("FAIL mid_old_word cyc=%0d got=%b/%h exp=0", c, bus.dec_valid, bus.dec_pc); end
            end else begin
                checks++; if (bus.dec_valid !== 1'b1 || bus.dec_pc !== 32'(4 * (c - 2))) begin
                    failures++; $display("FAIL mid_dec cyc=%0d got=%b/%h exp=1/%h", c, bus.dec_valid, bus.dec_pc, 32'(4 * (c - 2)));
                end
            end
            advance();
        end
    endtask

    task automatic test_random();
        logic [31:0] ideal;
        do_reset();
        ideal = 32'h0;
        for (int c = 0; c < 400; c++) begin
            logic        redir;
            logic [31:0] raddr;
            logic        dready;
            redir  = ($urandom_range(0, 15) == 0);
            raddr  = $urandom;
            dready = ($urandom_range(0, 3) != 0);
            drive(redir, raddr, dready);
            checks++; if (bus.iram_valid !== exp_iv) begin failures++; $display("FAIL rnd_iram_valid cyc=%0d got=%b exp=%b", c, bus.iram_valid, exp_iv); end
            if (exp_iv) begin
                checks++; if (bus.iram_addr !== exp_ia) begin failures++; $display("FAIL rnd_iram_addr cyc=%0d got=%h exp=%h", c, bus.iram_addr, exp_ia); end
            end
            checks++; if (bus.dec_valid !== exp_dv) begin failures++; $display("FAIL rnd_dec_valid cyc=%0d got=%b exp=%b", c, bus.dec_valid, exp_dv); end
            if (exp_dv) begin
                checks++; if (bus.dec_pc !== exp_dpc || bus.dec_instr !== mem(exp_dpc)) begin
                    failures++; $display("FAIL rnd_dec_data cyc=%0d got=%h/%h exp=%h/%h", c, bus.dec_pc, bus.dec_instr, exp_dpc, mem(exp_dpc));
                end
                if (dready) begin
                    checks++; if (bus.dec_pc !== ideal) begin failures++; $display("FAIL rnd_ideal_pc cyc=%0d got=%h exp=%h", c, bus.dec_pc, ideal); end
                    ideal = ideal + 32'd4;
                end
            end
            if (redir) ideal = raddr & ~32'd3;
            advance();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_back_to_back();
        test_wrap();
        test_reset_midstream();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
